mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter between the instruction cache and the data cache of the CPU core and the single shared main-memory port.
- Accepts line-granular read/write misses from both caches.
- Grants one at a time (round-robin on conflict) and holds the grant until memory answers.
- Returns a one-cycle ready pulse to the winner.
- Sits between the two caches and the memory model the testbench observes.
- Includes a watchdog that flags a memory transaction that never completes.

## Interface
- ADDR_W, 28, line address width (word address minus line offset)
- LINE_W, 128, cache line width in bits
- TIMEOUT, 1023, BUSY cycles after which `timeout` asserts
---
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ic_read  in  1  I-cache line read request, level, held until ic_ready
- ic_addr  in  ADDR_W  I-cache line address
- ic_rdata  out  LINE_W  read data to I-cache
- ic_ready  out  1  one-cycle completion pulse to I-cache
- dc_read  in  1  D-cache line read request, level
- dc_write  in  1  D-cache write-back request, level
- dc_addr  in  ADDR_W  D-cache line address
- dc_wdata  in  LINE_W  D-cache write-back data
- dc_rdata  out  LINE_W  read data to D-cache
- dc_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe, registered
- mem_write  out  1  memory write strobe, registered
- mem_addr  out  ADDR_W  memory line address, registered
- mem_wdata  out  LINE_W  memory write data, registered
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle
- busy  out  1  high in BUSY and RELEASE
- timeout  out  1  sticky watchdog flag, cleared only by rst

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Requests: I = ic_read; D = dc_read | dc_write.
  - Only one requester active: grant it.
  - Both active: grant the requester not granted last (`last_gnt`). After reset `last_gnt` = I, so D wins the first conflict.
  - On grant, latch the mode: D with dc_write=1 is a write, even if dc_read=1 too.
  - On grant, load mem_addr, mem_wdata, mem_read and mem_write from the winner, update `last_gnt`, and go to BUSY.
  - No request: stay in IDLE with all mem_* strobes 0.
- BUSY:
  - Mem strobes and address stay stable.
  - Requester inputs are ignored. A dropped request does not abort the transaction.
  - When mem_ready=1, pulse ready to the granted cache only, then go to RELEASE.
- RELEASE:
  - mem_read and mem_write are 0 for exactly one cycle.
  - The cache deasserts or changes its request in this cycle.
  - Unconditionally return to IDLE.
- Read data:
  - ic_rdata = dc_rdata = mem_rdata, combinational pass-through.
  - Valid only in the cycle its ready pulse is high.
- mem_ready outside BUSY is ignored; no ready pulse is generated.
- Watchdog:
  - 16-bit counter clears on entry to BUSY and increments every BUSY cycle, saturating at 0xFFFF.
  - When count == TIMEOUT, `timeout` sets and stays set.
  - The FSM keeps waiting and never aborts.

## Timing
- Reset values:
  - State IDLE, `last_gnt` = I.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - ic_ready = 0, dc_ready = 0, busy = 0, timeout = 0, watchdog counter = 0.
- Reset asserted mid-BUSY: next edge returns to IDLE with strobes 0; the pending transaction is dropped silently.
- Request seen in IDLE at cycle t: mem strobe high from t+1.
- mem_ready at cycle t+k (k ≥ 1): matching ready is high in cycle t+k, combinational from mem_ready. This cycle is RELEASE at t+k+1 and IDLE at t+k+2.
- Minimum spacing between two grants: 3 cycles when memory answers in 1 cycle.
- ic_ready and dc_ready are never high in the same cycle.

## Structure
- Shared package `arb_pkg`:
  - State encoding: IDLE=2'b00, BUSY=2'b01, RELEASE=2'b10.
  - Grant enum: GNT_I=1'b0, GNT_D=1'b1.
  - Default ADDR_W and LINE_W constants, reused by the caches.
- One sub-module, `mem_arb_watchdog`: saturating counter plus sticky flag, with inputs clk, rst, clr and en.
- Top level: FSM, grant mux and output registers.

## Test plan
- Reset, then ic_read=1, ic_addr=0x0000010, mem_ready after 3 cycles with mem_rdata=0x…DEADBEEF:
  - mem_read=1 and mem_addr=0x0000010 from the cycle after the request.
  - ic_ready is a single pulse and ic_rdata=0x…DEADBEEF.
  - dc_ready stays 0.
- ic_read and dc_read both high from reset, each held until its own ready:
  - D is granted first, then I.
  - A second simultaneous pair then grants D again, showing round-robin.
- dc_write=1, dc_read=1, dc_addr=0x0ABCDEF, dc_wdata=0x1234:
  - mem_write=1, mem_read=0, mem_wdata=0x1234.
  - dc_ready pulses once.
- Request dropped mid-BUSY: strobes stay stable until mem_ready, then RELEASE gives one cycle with both strobes 0, then IDLE.
- mem_ready pulse while IDLE: no ready pulse, no state change.
- mem_ready withheld for 1100 cycles:
  - timeout rises after 1023 BUSY cycles and stays 1 after completion.
  - rst clears it and returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default widths for the cache/memory arbiter
package arb_pkg;

  localparam int ARB_ADDR_W  = 28;
  localparam int ARB_LINE_W  = 128;
  localparam int ARB_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY    = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - saturating busy-cycle counter with sticky timeout flag
module mem_arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end
  end

  // Flag rises on the edge where the count reaches TIMEOUT, then stays until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      timeout <= 1'b0;
    end else begin
      count_q <= count_d;
      if (en && count_d == TIMEOUT_C) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter between I-cache and D-cache for one memory port
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int LINE_W  = ARB_LINE_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout
);

  state_t state_q, state_d;
  gnt_t   last_gnt_q, gnt_d;
  logic   load;
  logic   wr_d;
  logic   i_req, d_req;
  logic   done;

  assign i_req = ic_read;
  assign d_req = dc_read | dc_write;

  always_comb begin
    state_d = state_q;
    gnt_d   = last_gnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          load    = 1'b1;
          state_d = ST_BUSY;
          if (i_req && d_req) begin
            gnt_d = (last_gnt_q == GNT_I) ? GNT_D : GNT_I;
          end else begin
            gnt_d = d_req ? GNT_D : GNT_I;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A D-cache write-back takes precedence over a simultaneous D-cache read.
  assign wr_d = (gnt_d == GNT_D) && dc_write;
  assign done = (state_q == ST_BUSY) && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= GNT_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        last_gnt_q <= gnt_d;
        mem_read   <= ~wr_d;
        mem_write  <= wr_d;
        mem_addr   <= (gnt_d == GNT_D) ? dc_addr : ic_addr;
        mem_wdata  <= (gnt_d == GNT_D) ? dc_wdata : '0;
      end else if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end

  // last_gnt_q doubles as the owner of the transaction in flight.
  assign ic_ready = done && (last_gnt_q == GNT_I);
  assign dc_ready = done && (last_gnt_q == GNT_D);
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;
  assign busy     = (state_q != ST_IDLE);

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (load),
    .en     (state_q == ST_BUSY),
    .timeout(timeout)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [LW-1:0] RDATA = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_read = 1'b0;
  logic [AW-1:0] ic_addr = 28'h0000010;
  logic [LW-1:0] ic_rdata;
  logic          ic_ready;
  logic          dc_read = 1'b0;
  logic          dc_write = 1'b0;
  logic [AW-1:0] dc_addr = 28'h0000020;
  logic [LW-1:0] dc_wdata = '0;
  logic [LW-1:0] dc_rdata;
  logic          dc_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = RDATA;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .ic_read  (ic_read),
    .ic_addr  (ic_addr),
    .ic_rdata (ic_rdata),
    .ic_ready (ic_ready),
    .dc_read  (dc_read),
    .dc_write (dc_write),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_rdata (dc_rdata),
    .dc_ready (dc_ready),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct {
    logic          rst;
    logic          chk;
    logic          ic;
    logic          dr;
    logic          dw;
    logic          mr;
    logic          e_rd;
    logic          e_wr;
    logic          e_icr;
    logic          e_dcr;
    logic          e_busy;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst chk ic dr dw mr | rd wr icr dcr busy addr
    // single I-cache read, memory answers 3 cycles after the request
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 28'h0});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 28'h0});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 28'h10});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 28'h10});
    vecs.push_back('{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 28'h10});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 28'h10});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 28'h10});
    // conflicts from reset: D, then I, then D again; finally mem_ready while idle
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 28'h0});
    vecs.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 28'h0});
    vecs.push_back('{0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1, 28'h20});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 28'h20});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 28'h20});
    vecs.push_back('{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 28'h10});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 28'h10});
    vecs.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 28'h10});
    vecs.push_back('{0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1, 28'h20});
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 28'h20});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 28'h20});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 28'h20});

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_timeout", timeout, 0);
    check("reset_wdata", mem_wdata, 0);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      ic_read   = vecs[i].ic;
      dc_read   = vecs[i].dr;
      dc_write  = vecs[i].dw;
      mem_ready = vecs[i].mr;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_mem_read", i), mem_read, vecs[i].e_rd);
        check($sformatf("v%0d_mem_write", i), mem_write, vecs[i].e_wr);
        check($sformatf("v%0d_ic_ready", i), ic_ready, vecs[i].e_icr);
        check($sformatf("v%0d_dc_ready", i), dc_ready, vecs[i].e_dcr);
        check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
        check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        if (vecs[i].e_icr) check($sformatf("v%0d_ic_rdata", i), ic_rdata, RDATA);
        if (vecs[i].e_dcr) check($sformatf("v%0d_dc_rdata", i), dc_rdata, RDATA);
      end
      tick();
    end
    rst = 1'b0; ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0; mem_ready = 1'b0;

    // write-back wins over a simultaneous read on the D side
    dc_write = 1'b1; dc_read = 1'b1; dc_addr = 28'h0ABCDEF; dc_wdata = 128'h1234;
    tick();
    check("wb_mem_write", mem_write, 1);
    check("wb_mem_read", mem_read, 0);
    check("wb_mem_wdata", mem_wdata, 128'h1234);
    check("wb_mem_addr", mem_addr, 28'h0ABCDEF);
    tick();
    mem_ready = 1'b1;
    #1;
    check("wb_dc_ready", dc_ready, 1);
    check("wb_ic_ready", ic_ready, 0);
    tick();
    mem_ready = 1'b0; dc_write = 1'b0; dc_read = 1'b0;
    #1;
    check("wb_release_write", mem_write, 0);
    check("wb_release_dc_ready", dc_ready, 0);
    check("wb_release_busy", busy, 1);
    tick();
    check("wb_idle_busy", busy, 0);

    // request dropped while busy: transaction still completes
    ic_read = 1'b1;
    tick();
    ic_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("drop_c%0d_read", c), mem_read, 1);
      check($sformatf("drop_c%0d_addr", c), mem_addr, 28'h10);
      check($sformatf("drop_c%0d_ic_ready", c), ic_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("drop_ic_ready", ic_ready, 1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("drop_release_read", mem_read, 0);
    check("drop_release_write", mem_write, 0);
    check("drop_release_busy", busy, 1);
    tick();
    check("drop_idle_busy", busy, 0);

    // reset in the middle of a transaction drops it
    ic_read = 1'b1;
    tick();
    ic_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_read", mem_read, 0);
    mem_ready = 1'b1;
    #1;
    check("midrst_no_ready", ic_ready, 0);
    tick();
    mem_ready = 1'b0;
    check("midrst_still_idle", busy, 0);

    // watchdog: memory silent for 1100 cycles
    ic_read = 1'b1;
    tick();
    ic_read = 1'b0;
    repeat (1022) tick();
    check("wd_before", timeout, 0);
    tick();
    check("wd_at_limit", timeout, 1);
    check("wd_still_busy", busy, 1);
    repeat (76) tick();
    mem_ready = 1'b1;
    #1;
    check("wd_late_ready", ic_ready, 1);
    tick();
    mem_ready = 1'b0;
    tick();
    check("wd_sticky", timeout, 1);
    check("wd_idle", busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_rst_timeout", timeout, 0);
    check("wd_rst_busy", busy, 0);
    check("wd_rst_read", mem_read, 0);
    check("wd_rst_addr", mem_addr, 0);
    check("wd_rst_ready", ic_ready | dc_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
